// File: rtl/solver_pkg.sv
// Shared widths, FSM state encoding and defaults for the quadratic-solver arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package solver_pkg;

   localparam int X_W                = 8;    // operand x width
   localparam int COEF_W             = 16;   // coefficient / result width
   localparam int DEF_TIMEOUT_CYCLES = 255;  // default watchdog limit

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_VALID,
      WAIT_READY
   } state_t;

endpackage

// File: rtl/solver_arbiter_rr_picker.sv
// Round-robin picker: first set req bit at or above pointer, wrapping N-1 -> 0.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is taken.
//
// Ports:
//   req       - request vector
//   pointer   - highest-priority index for this pick (must be < N)
//   grant     - one-hot grant, all zero when req is zero
//   grant_idx - binary index of the granted bit (0 when req is zero)
module rr_picker #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] pointer,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx
);

   localparam logic [IW:0] N_EXT = (IW+1)'(N);

   always_comb begin : pick
      logic [IW:0] pos;
      logic        found;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      pos       = '0;
      for (int k = 0; k < N; k++) begin
         // candidate = (pointer + k) mod N, one extra bit so the sum cannot overflow
         pos = {1'b0, pointer} + (IW+1)'(k);
         if (pos >= N_EXT) begin
            pos = pos - N_EXT;
         end
         if (!found && req[pos[IW-1:0]]) begin
            found                 = 1'b1;
            grant[pos[IW-1:0]]    = 1'b1;
            grant_idx             = pos[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/solver_arbiter.sv
// Shares one quadratic solver (y = a*x^2 + b*x + c) between N requesters, round-robin.
// Latency: req seen -> sol_enable next cycle; done one cycle after the sol_valid rising edge.
// Backpressure: no grant while sol_ready is low; a job holds the solver until sol_ready returns.
//
// Ports:
//   clock, reset             - rising-edge clock, asynchronous active-high reset
//   req, req_x/a/b/c         - per-client request level and packed operands (client i at slice i)
//   done, rsp_y, rsp_err     - one-cycle one-hot completion pulse, result and timeout flag
//   busy                     - high whenever a job is in flight (FSM not IDLE)
//   sol_x/a/b/c, sol_enable  - registered operands and one-cycle start pulse to the solver
//   sol_reset                - solver reset, follows reset
//   sol_y, sol_valid, sol_ready - solver result, result-valid and idle/accepting
//
// Build option: define SOLVER_TIMEOUT_EN to add a WAIT_VALID watchdog of TIMEOUT_CYCLES cycles
// that completes the job with rsp_err=1 and rsp_y=0; without it rsp_err is tied low.
module solver_arbiter
   import solver_pkg::*;
#(
   parameter int N              = 4,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [N-1:0]          req,
   input  logic [X_W*N-1:0]      req_x,
   input  logic [COEF_W*N-1:0]   req_a,
   input  logic [COEF_W*N-1:0]   req_b,
   input  logic [COEF_W*N-1:0]   req_c,
   output logic [N-1:0]          done,
   output logic [COEF_W-1:0]     rsp_y,
   output logic                  rsp_err,
   output logic                  busy,
   output logic [X_W-1:0]        sol_x,
   output logic [COEF_W-1:0]     sol_a,
   output logic [COEF_W-1:0]     sol_b,
   output logic [COEF_W-1:0]     sol_c,
   output logic                  sol_enable,
   output logic                  sol_reset,
   input  logic [COEF_W-1:0]     sol_y,
   input  logic                  sol_valid,
   input  logic                  sol_ready
);

   localparam int            IW   = $clog2(N);
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   state_t        state;
   logic [IW-1:0] pointer;
   logic [IW-1:0] winner;
   logic [N-1:0]  winner_oh;
   logic [N-1:0]  pick_grant;
   logic [IW-1:0] pick_idx;
   logic          valid_q;
   logic          valid_rise;

   rr_picker #(.N(N), .IW(IW)) u_pick (
      .req       (req),
      .pointer   (pointer),
      .grant     (pick_grant),
      .grant_idx (pick_idx)
   );

   // Only a fresh 0->1 transition completes a job, so a valid level left
   // high by the previous job cannot complete the next one.
   assign valid_rise = sol_valid & ~valid_q;
   assign busy       = (state != IDLE);
   assign sol_reset  = reset;

`ifdef SOLVER_TIMEOUT_EN
   localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [TW-1:0] tmo_cnt;
`else
   logic timeout_unused;
   assign timeout_unused = |TIMEOUT_CYCLES;
   assign rsp_err        = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         pointer    <= '0;
         winner     <= '0;
         winner_oh  <= '0;
         valid_q    <= 1'b0;
         done       <= '0;
         rsp_y      <= '0;
         sol_x      <= '0;
         sol_a      <= '0;
         sol_b      <= '0;
         sol_c      <= '0;
         sol_enable <= 1'b0;
`ifdef SOLVER_TIMEOUT_EN
         rsp_err    <= 1'b0;
         tmo_cnt    <= '0;
`endif
      end else begin
         valid_q    <= sol_valid;
         done       <= '0;
         sol_enable <= 1'b0;
`ifdef SOLVER_TIMEOUT_EN
         rsp_err    <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if ((|req) && sol_ready) begin
                  winner     <= pick_idx;
                  winner_oh  <= pick_grant;
                  sol_x      <= req_x[pick_idx*X_W +: X_W];
                  sol_a      <= req_a[pick_idx*COEF_W +: COEF_W];
                  sol_b      <= req_b[pick_idx*COEF_W +: COEF_W];
                  sol_c      <= req_c[pick_idx*COEF_W +: COEF_W];
                  sol_enable <= 1'b1;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
`ifdef SOLVER_TIMEOUT_EN
               tmo_cnt <= '0;
`endif
               state <= WAIT_VALID;
            end
            WAIT_VALID: begin
               if (valid_rise) begin
                  rsp_y <= sol_y;
                  done  <= winner_oh;
                  state <= WAIT_READY;
`ifdef SOLVER_TIMEOUT_EN
               end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                  // this is the TIMEOUT_CYCLES-th cycle spent waiting
                  rsp_y   <= '0;
                  rsp_err <= 1'b1;
                  done    <= winner_oh;
                  state   <= WAIT_READY;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
`endif
               end
            end
            WAIT_READY: begin
               if (sol_ready) begin
                  pointer <= (winner == LAST) ? '0 : winner + 1'b1;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_solver_arbiter.sv
// Directed bench for solver_arbiter with a behavioural solver and an arbitration scoreboard.
// Latency: n/a.
// Backpressure: the solver model drops sol_ready while computing and can delay it after valid.
module tb_solver_arbiter;

   localparam int N   = 4;
   localparam int TMO = 40;

   logic              clock = 1'b0;
   logic              reset;
   logic [N-1:0]      req;
   logic [8*N-1:0]    req_x;
   logic [16*N-1:0]   req_a, req_b, req_c;
   logic [N-1:0]      done;
   logic [15:0]       rsp_y;
   logic              rsp_err, busy;
   logic [7:0]        sol_x;
   logic [15:0]       sol_a, sol_b, sol_c, sol_y;
   logic              sol_enable, sol_reset, sol_valid, sol_ready;

   solver_arbiter #(.N(N), .TIMEOUT_CYCLES(TMO)) dut (
      .clock(clock), .reset(reset), .req(req),
      .req_x(req_x), .req_a(req_a), .req_b(req_b), .req_c(req_c),
      .done(done), .rsp_y(rsp_y), .rsp_err(rsp_err), .busy(busy),
      .sol_x(sol_x), .sol_a(sol_a), .sol_b(sol_b), .sol_c(sol_c),
      .sol_enable(sol_enable), .sol_reset(sol_reset),
      .sol_y(sol_y), .sol_valid(sol_valid), .sol_ready(sol_ready)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_true(input string name, input bit cond);
      check_eq(name, longint'(cond), 1);
   endtask

   function automatic logic [15:0] quad(input logic signed [7:0] x, input logic signed [15:0] a,
                                        input logic signed [15:0] b, input logic signed [15:0] c);
      int r;
      r = int'(a) * int'(x) * int'(x) + int'(b) * int'(x) + int'(c);
      return r[15:0];
   endfunction

   // ---------------- behavioural solver ----------------
   bit hold_valid = 1'b0;   // keep valid high between jobs
   bit mute       = 1'b0;   // never raise valid
   int lat        = 5;
   int rdly       = 0;      // extra cycles of sol_ready low after valid
   int scnt       = 0;
   int rcnt       = 0;
   logic [15:0] sres;

   initial begin
      sol_valid = 1'b0; sol_ready = 1'b1; sol_y = '0; sres = '0;
      forever begin
         @(negedge clock);
         if (sol_reset) begin
            sol_valid = 1'b0; sol_ready = 1'b1; scnt = 0; rcnt = 0;
         end else begin
            if (!hold_valid) sol_valid = 1'b0;
            if (sol_enable) begin
               sres = quad(sol_x, sol_a, sol_b, sol_c);
               scnt = lat; sol_ready = 1'b0;
            end else if (scnt != 0) begin
               if (scnt == 2) sol_valid = 1'b0;
               if (scnt == 1) begin
                  if (!mute) begin sol_valid = 1'b1; sol_y = sres; end
                  if (rdly == 0) sol_ready = 1'b1; else rcnt = rdly;
               end
               scnt--;
            end else if (rcnt != 0) begin
               if (rcnt == 1) sol_ready = 1'b1;
               rcnt--;
            end
         end
      end
   end

   // ---------------- arbitration scoreboard ----------------
   int n_enable = 0;
   int served[$];

   initial begin
      bit outstanding, fresh, exp_tmo, prev_valid, ok;
      int model_ptr, exp_idx, en_cycle, cyc, w;
      logic signed [15:0] exp_y;
      outstanding = 0; fresh = 0; exp_tmo = 0; prev_valid = 0;
      model_ptr = 0; exp_idx = 0; en_cycle = 0; cyc = 0; exp_y = '0;
      forever begin
         @(posedge clock);
         #1;
         cyc++;
         if (reset) begin
            outstanding = 0; fresh = 0; model_ptr = 0;
         end else begin
            if (outstanding && sol_valid && !prev_valid) fresh = 1;
            if (done != '0) begin
               if (!outstanding) begin
                  check_eq("spurious_done", longint'(done), 0);
               end else begin
                  check_eq("done_onehot", longint'(done), longint'(1 << exp_idx));
                  check_eq("rsp_err", longint'(rsp_err), longint'(exp_tmo));
                  check_eq("rsp_y", longint'($signed(rsp_y)), exp_tmo ? 0 : longint'(exp_y));
                  if (exp_tmo) check_true("tmo_latency", (cyc - en_cycle >= TMO) && (cyc - en_cycle <= TMO + 3));
                  else         check_true("done_after_edge", fresh);
                  served.push_back(exp_idx);
                  model_ptr   = (exp_idx + 1) % N;
                  outstanding = 0;
               end
            end
            if (sol_enable) begin
               n_enable++;
               check_true("enable_while_busy", !outstanding);
               check_true("enable_needs_ready", sol_ready);
               w = -1;
               for (int k = 0; k < N; k++) begin
                  if (w < 0 && req[(model_ptr + k) % N]) w = (model_ptr + k) % N;
               end
               check_true("enable_needs_req", w >= 0);
               if (w >= 0) begin
                  check_eq("sol_x", longint'($signed(sol_x)), longint'($signed(req_x[8*w +: 8])));
                  check_eq("sol_a", longint'($signed(sol_a)), longint'($signed(req_a[16*w +: 16])));
                  check_eq("sol_b", longint'($signed(sol_b)), longint'($signed(req_b[16*w +: 16])));
                  check_eq("sol_c", longint'($signed(sol_c)), longint'($signed(req_c[16*w +: 16])));
                  exp_idx = w;
                  exp_y   = quad(req_x[8*w +: 8], req_a[16*w +: 16], req_b[16*w +: 16], req_c[16*w +: 16]);
               end
               outstanding = 1; fresh = 0; exp_tmo = mute; en_cycle = cyc;
            end else if (outstanding) begin
               ok = busy && sol_x == req_x[8*exp_idx +: 8] && sol_a == req_a[16*exp_idx +: 16]
                    && sol_b == req_b[16*exp_idx +: 16] && sol_c == req_c[16*exp_idx +: 16];
               check_true("busy_ops_stable", ok);
            end
         end
         prev_valid = sol_valid;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_ops(input int i, input logic signed [7:0] x, input logic signed [15:0] a,
                          input logic signed [15:0] b, input logic signed [15:0] c);
      req_x[8*i +: 8]   = x;
      req_a[16*i +: 16] = a;
      req_b[16*i +: 16] = b;
      req_c[16*i +: 16] = c;
   endtask

   task automatic wait_done(input string name, output logic [N-1:0] dv, output int idx,
                            output logic signed [15:0] y, output logic err);
      dv = '0; idx = -1; y = '0; err = 1'b0;
      for (int t = 0; t < 300; t++) begin
         @(negedge clock);
         if (done != '0) begin
            dv = done; y = rsp_y; err = rsp_err;
            for (int k = N - 1; k >= 0; k--) if (done[k]) idx = k;
            return;
         end
      end
      check_eq({name, "_timeout"}, 0, 1);
   endtask

   task automatic wait_idle(input string name);
      bit seen;
      seen = 1'b0;
      for (int t = 0; t < 12 && !seen; t++) begin
         @(negedge clock);
         if (!busy) seen = 1'b1;
      end
      check_true(name, seen);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      logic [N-1:0]       dv;
      int                 idx, e0, nd;
      logic signed [15:0] y;
      logic               err;
      int                 exp_order[8];
      exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};

      reset = 1'b1; req = '0; req_x = '0; req_a = '0; req_b = '0; req_c = '0;
      repeat (3) @(negedge clock);
      check_eq("rst_done",       longint'(done), 0);
      check_eq("rst_rsp_y",      longint'(rsp_y), 0);
      check_eq("rst_rsp_err",    longint'(rsp_err), 0);
      check_eq("rst_busy",       longint'(busy), 0);
      check_eq("rst_sol_enable", longint'(sol_enable), 0);
      check_eq("rst_sol_x",      longint'(sol_x), 0);
      check_eq("rst_sol_a",      longint'(sol_a), 0);
      check_eq("rst_sol_c",      longint'(sol_c), 0);
      check_eq("rst_sol_reset",  longint'(sol_reset), 1);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      check_eq("run_sol_reset",  longint'(sol_reset), 0);

      // single client 0: 1*4 + 2*2 + 3 = 11
      e0 = n_enable;
      set_ops(0, 8'sd2, 16'sd1, 16'sd2, 16'sd3);
      req = 4'b0001;
      @(posedge clock); #1;
      check_eq("t1_enable_next_cycle", longint'(sol_enable), 1);
      check_eq("t1_busy", longint'(busy), 1);
      wait_done("t1", dv, idx, y, err);
      req[0] = 1'b0;
      check_eq("t1_done", longint'(dv), 4'b0001);
      check_eq("t1_y", longint'(y), 11);
      wait_idle("t1_busy_falls");
      check_eq("t1_enables", n_enable - e0, 1);

      // clients 1 and 3 together, pointer at 1: 2*9 - 5 = 13, then 7
      set_ops(1, -8'sd3, 16'sd2, 16'sd0, -16'sd5);
      set_ops(3, 8'sd0, 16'sd0, 16'sd0, 16'sd7);
      req = 4'b1010;
      wait_done("t2a", dv, idx, y, err);
      req[1] = 1'b0;
      check_eq("t2_first_done", longint'(dv), 4'b0010);
      check_eq("t2_first_y", longint'(y), 13);
      wait_done("t2b", dv, idx, y, err);
      req[3] = 1'b0;
      check_eq("t2_second_done", longint'(dv), 4'b1000);
      check_eq("t2_second_y", longint'(y), 7);
      wait_idle("t2_idle");

      // all four clients, two jobs each, with slow ready release
      rdly = 2;
      for (int i = 0; i < N; i++) set_ops(i, 8'(i + 1), 16'sd1, -16'sd1, 16'(10 * i));
      req = 4'b1111;
      for (int j = 0; j < 8; j++) begin
         wait_done("t3", dv, idx, y, err);
         check_eq("t3_grant_order", idx, exp_order[j]);
         if (idx >= 0) begin
            req[idx] = 1'b0;
            @(negedge clock);
            if (j < 4) req[idx] = 1'b1;
         end
      end
      wait_idle("t3_idle");
      rdly = 0;

      // stale valid level: client 2 (=3) then client 0 (3 - 4 + 5 = 4)
      hold_valid = 1'b1;
      set_ops(2, 8'sd1, 16'sd1, 16'sd1, 16'sd1);
      req = 4'b0100;
      wait_done("t4a", dv, idx, y, err);
      req = '0;
      check_eq("t4_first_done", longint'(dv), 4'b0100);
      check_eq("t4_first_y", longint'(y), 3);
      wait_idle("t4_idle_a");
      set_ops(0, -8'sd1, 16'sd3, 16'sd4, 16'sd5);
      req = 4'b0001;
      wait_done("t4b", dv, idx, y, err);
      req = '0;
      check_eq("t4_second_done", longint'(dv), 4'b0001);
      check_eq("t4_second_y", longint'(y), 4);
      hold_valid = 1'b0;
      wait_idle("t4_idle_b");

      // reset while waiting for valid (pointer is 1 beforehand)
      lat = 20;
      set_ops(3, 8'sd1, 16'sd0, 16'sd0, 16'sd9);
      req = 4'b1000;
      repeat (6) @(negedge clock);
      check_eq("t5_busy_before", longint'(busy), 1);
      reset = 1'b1; req = '0;
      #1;
      check_eq("t5_async_busy", longint'(busy), 0);
      check_eq("t5_async_done", longint'(done), 0);
      check_eq("t5_async_enable", longint'(sol_enable), 0);
      check_eq("t5_async_sol_x", longint'(sol_x), 0);
      check_eq("t5_async_sol_c", longint'(sol_c), 0);
      repeat (2) @(negedge clock);
      reset = 1'b0; lat = 5;
      nd = 0;
      repeat (30) begin
         @(negedge clock);
         if (done != '0) nd++;
      end
      check_eq("t5_no_done_after_abort", nd, 0);
      // pointer back at 0: client 0 (-9 + 15 = 6) before client 2 (16 + 6 + 1 = 23)
      set_ops(0, 8'sd3, -16'sd1, 16'sd5, 16'sd0);
      set_ops(2, -8'sd2, 16'sd4, -16'sd3, 16'sd1);
      req = 4'b0101;
      wait_done("t5a", dv, idx, y, err);
      req[0] = 1'b0;
      check_eq("t5_first_done", longint'(dv), 4'b0001);
      check_eq("t5_first_y", longint'(y), 6);
      wait_done("t5b", dv, idx, y, err);
      req[2] = 1'b0;
      check_eq("t5_second_done", longint'(dv), 4'b0100);
      check_eq("t5_second_y", longint'(y), 23);
      wait_idle("t5_idle");

`ifdef SOLVER_TIMEOUT_EN
      // solver never answers: watchdog completes the job with an error
      mute = 1'b1;
      set_ops(1, 8'sd1, 16'sd1, 16'sd1, 16'sd1);
      req = 4'b0010;
      wait_done("t6", dv, idx, y, err);
      req = '0;
      check_eq("t6_done", longint'(dv), 4'b0010);
      check_eq("t6_err", longint'(err), 1);
      check_eq("t6_y", longint'(y), 0);
      mute = 1'b0;
      wait_idle("t6_idle");
`endif

      repeat (3) @(negedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
